// File: rtl/transition_predictor_if.sv
// -----------------------------------------------------------------------------
// transition_predictor_if
// Round handshake between the game front end and the Markov opponent.
//   round_valid  one-cycle pulse, user move committed
//   user[1:0]    user move: 00 rock, 01 scissor, 10 paper, 11 invalid
//   choice[1:0]  computer move for the next round
//   predicted    predicted next user move
//   ready        choice is valid for the next round
//   overrun      one-cycle pulse, a round_valid was dropped while busy
//   last_move    most recently accepted user move
// master: the side that commits rounds; slave: the predictor.
// -----------------------------------------------------------------------------
interface transition_predictor_if;
    logic       round_valid;
    logic [1:0] user;
    logic [1:0] choice;
    logic [1:0] predicted;
    logic       ready;
    logic       overrun;
    logic [1:0] last_move;

    modport master (
        output round_valid, user,
        input  choice, predicted, ready, overrun, last_move
    );

    modport slave (
        input  round_valid, user,
        output choice, predicted, ready, overrun, last_move
    );
endinterface

// File: rtl/transition_predictor.sv
// -----------------------------------------------------------------------------
// transition_predictor
// First-order Markov opponent for rock-paper-scissors. Counts how often each
// user move follows each previous user move, predicts the most likely next
// move and offers the move that beats it.
//
// Ports:
//   clock  system clock (CLOCK_50)
//   reset  synchronous, active-high
//   bus    transition_predictor_if.slave (round_valid/user in,
//          choice/predicted/ready/overrun/last_move out)
// Parameters:
//   CNT_W  width of each transition counter (saturates at 2^CNT_W-1)
// Build option:
//   PREDICTOR_DECAY_EN  when defined, a saturated counter halves its row
//                       (one counter per cycle) before incrementing; when
//                       undefined, a saturated counter simply stays at max.
// -----------------------------------------------------------------------------
module transition_predictor #(
    parameter int CNT_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    transition_predictor_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef PREDICTOR_DECAY_EN
    typedef enum logic [2:0] {EMPTY, READY, UPDATE, PREDICT, HALVE} state_t;
`else
    typedef enum logic [2:0] {EMPTY, READY, UPDATE, PREDICT} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt [3][3];
    logic [1:0]       prev;
    logic [1:0]       last_move_r;
    logic [1:0]       predicted_r;
    logic [1:0]       choice_r;
    logic             overrun_r;
    logic             has_prev;
`ifdef PREDICTOR_DECAY_EN
    logic [1:0]       idx;
    logic             do_halve;
    logic             start_halve;
`endif

    logic             vld_mv;
    logic             accept;
    logic             drop;
    logic             do_inc;
    logic             do_pred;
    logic [CNT_W-1:0] tgt;
    logic [1:0]       pred_mv;

    // Argmax over one row; strict compare makes ties go to the lowest code.
    function automatic logic [1:0] argmax3(input logic [CNT_W-1:0] c0,
                                           input logic [CNT_W-1:0] c1,
                                           input logic [CNT_W-1:0] c2);
        logic [1:0]       best;
        logic [CNT_W-1:0] bv;
        best = 2'd0;
        bv   = c0;
        if (c1 > bv) begin
            best = 2'd1;
            bv   = c1;
        end
        if (c2 > bv) begin
            best = 2'd2;
        end
        return best;
    endfunction

    // Move that beats m: rock->paper, scissor->rock, paper->scissor.
    function automatic logic [1:0] counter_move(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'b00:   r = 2'b10;
            2'b01:   r = 2'b00;
            2'b10:   r = 2'b01;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    assign tgt     = cnt[prev][last_move_r];
    assign pred_mv = argmax3(cnt[last_move_r][0], cnt[last_move_r][1],
                             cnt[last_move_r][2]);

    assign bus.ready     = (state == EMPTY) || (state == READY);
    assign bus.choice    = choice_r;
    assign bus.predicted = predicted_r;
    assign bus.overrun   = overrun_r;
    assign bus.last_move = last_move_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        do_inc    = 1'b0;
        do_pred   = 1'b0;
`ifdef PREDICTOR_DECAY_EN
        do_halve    = 1'b0;
        start_halve = 1'b0;
`endif
        // Invalid moves (11) are ignored everywhere, including for overrun.
        vld_mv = bus.round_valid && (bus.user != 2'b11);
        case (state)
            EMPTY, READY: begin
                if (vld_mv) begin
                    accept    = 1'b1;
                    state_nxt = has_prev ? UPDATE : PREDICT;
                end
            end
            UPDATE: begin
                drop = vld_mv;
                if (tgt != CNT_MAX) begin
                    do_inc    = 1'b1;
                    state_nxt = PREDICT;
                end else begin
`ifdef PREDICTOR_DECAY_EN
                    start_halve = 1'b1;
                    state_nxt   = HALVE;
`else
                    state_nxt   = PREDICT;
`endif
                end
            end
`ifdef PREDICTOR_DECAY_EN
            HALVE: begin
                drop     = vld_mv;
                do_halve = 1'b1;
                // After the last entry the retried increment is guaranteed
                // to succeed since the target is now below max.
                if (idx == 2'd2) begin
                    state_nxt = UPDATE;
                end
            end
`endif
            PREDICT: begin
                drop      = vld_mv;
                do_pred   = 1'b1;
                state_nxt = READY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    cnt[i][j] <= '0;
                end
            end
            prev        <= 2'b00;
            last_move_r <= 2'b00;
            predicted_r <= 2'b00;
            choice_r    <= 2'b10;
            overrun_r   <= 1'b0;
            has_prev    <= 1'b0;
`ifdef PREDICTOR_DECAY_EN
            idx         <= 2'd0;
`endif
        end else begin
            overrun_r <= drop;
            if (accept) begin
                prev        <= last_move_r;
                last_move_r <= bus.user;
                has_prev    <= 1'b1;
            end
            if (do_inc) begin
                cnt[prev][last_move_r] <= tgt + CNT_W'(1);
            end
`ifdef PREDICTOR_DECAY_EN
            if (start_halve) begin
                idx <= 2'd0;
            end
            if (do_halve) begin
                cnt[prev][idx] <= cnt[prev][idx] >> 1;
                idx            <= idx + 2'd1;
            end
`endif
            if (do_pred) begin
                predicted_r <= pred_mv;
                choice_r    <= counter_move(pred_mv);
            end
        end
    end

endmodule

// File: tb/tb_transition_predictor.sv
// -----------------------------------------------------------------------------
// tb_transition_predictor
// Directed bench for transition_predictor: a vector table of rounds with
// hand-computed predictions and latencies, plus hand-written sequences for
// invalid moves, overrun, saturation/decay and reset during a busy state.
// -----------------------------------------------------------------------------
module tb_transition_predictor;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    transition_predictor_if pif();

    transition_predictor #(.CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (pif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] mv;
        logic [1:0] pred;
        logic [1:0] choice;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse one round, then count edges after the sampling edge until ready.
    task automatic send(input logic [1:0] mv, output int lat);
        @(negedge clock);
        pif.round_valid = 1'b1;
        pif.user        = mv;
        @(negedge clock);
        pif.round_valid = 1'b0;
        pif.user        = 2'b00;
        lat = 0;
        while (!pif.ready && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!pif.ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1");
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int s;

        vecs[0] = '{2'b00, 2'b00, 2'b10, 1};
        vecs[1] = '{2'b01, 2'b00, 2'b10, 2};
        vecs[2] = '{2'b00, 2'b01, 2'b00, 2};
        vecs[3] = '{2'b10, 2'b00, 2'b10, 2};
        vecs[4] = '{2'b01, 2'b00, 2'b10, 2};
        vecs[5] = '{2'b10, 2'b01, 2'b00, 2};
        vecs[6] = '{2'b10, 2'b01, 2'b00, 2};
        vecs[7] = '{2'b10, 2'b10, 2'b01, 2};

        pif.round_valid = 1'b0;
        pif.user        = 2'b00;
        reset           = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("rst_ready",     pif.ready,     1);
        chk("rst_choice",    pif.choice,    2);
        chk("rst_predicted", pif.predicted, 0);
        chk("rst_last_move", pif.last_move, 0);
        chk("rst_overrun",   pif.overrun,   0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].mv, lat);
            chk($sformatf("vec%0d_lat", i),       lat,           vecs[i].lat);
            chk($sformatf("vec%0d_predicted", i), pif.predicted, vecs[i].pred);
            chk($sformatf("vec%0d_choice", i),    pif.choice,    vecs[i].choice);
            chk($sformatf("vec%0d_last_move", i), pif.last_move, vecs[i].mv);
        end

        // Invalid move in READY: no state change, no overrun.
        @(negedge clock);
        pif.round_valid = 1'b1;
        pif.user        = 2'b11;
        @(negedge clock);
        pif.round_valid = 1'b0;
        pif.user        = 2'b00;
        chk("inv_ready",     pif.ready,     1);
        chk("inv_overrun",   pif.overrun,   0);
        chk("inv_choice",    pif.choice,    1);
        chk("inv_last_move", pif.last_move, 2);

        // Extra pulse during UPDATE is dropped and flagged.
        @(negedge clock);
        pif.round_valid = 1'b1;
        pif.user        = 2'b01;
        @(negedge clock);
        pif.user        = 2'b00;
        chk("ovr_ready_low", pif.ready, 0);
        @(negedge clock);
        pif.round_valid = 1'b0;
        chk("ovr_pulse",       pif.overrun, 1);
        chk("ovr_ready_busy",  pif.ready,   0);
        @(negedge clock);
        chk("ovr_pulse_end",   pif.overrun,   0);
        chk("ovr_ready",       pif.ready,     1);
        chk("ovr_predicted",   pif.predicted, 0);
        chk("ovr_choice",      pif.choice,    2);
        chk("ovr_last_move",   pif.last_move, 1);
        chk("ovr_cnt_PS",      dut.cnt[2][1], 2);
        chk("ovr_cnt_SR",      dut.cnt[1][0], 1);

        // Saturation: build cnt[R][S]=2, then 15 rock->rock transitions.
        do_reset();
        send(2'b00, lat);
        send(2'b01, lat);
        send(2'b00, lat);
        send(2'b01, lat);
        send(2'b00, lat);
        for (int k = 1; k <= 15; k++) begin
            send(2'b00, lat);
            chk($sformatf("sat_lat%0d", k), lat, 2);
        end
        chk("sat15_cnt_RR", dut.cnt[0][0], 15);
        chk("sat15_cnt_RS", dut.cnt[0][1], 2);
        chk("sat15_pred",   pif.predicted, 0);
        chk("sat15_choice", pif.choice,    2);

        send(2'b00, lat);
`ifdef PREDICTOR_DECAY_EN
        chk("sat16_lat",    lat,           6);
        chk("sat16_cnt_RR", dut.cnt[0][0], 8);
        chk("sat16_cnt_RS", dut.cnt[0][1], 1);
`else
        chk("sat16_lat",    lat,           2);
        chk("sat16_cnt_RR", dut.cnt[0][0], 15);
        chk("sat16_cnt_RS", dut.cnt[0][1], 2);
`endif
        chk("sat16_cnt_RP", dut.cnt[0][2], 0);
        chk("sat16_pred",   pif.predicted, 0);
        chk("sat16_choice", pif.choice,    2);

        // Reset while busy (mid-HALVE when decay is built in).
`ifdef PREDICTOR_DECAY_EN
        for (int k = 0; k < 7; k++) begin
            send(2'b00, lat);
        end
        chk("pre_rst_cnt_RR", dut.cnt[0][0], 15);
`endif
        @(negedge clock);
        pif.round_valid = 1'b1;
        pif.user        = 2'b00;
        @(negedge clock);
        pif.round_valid = 1'b0;
`ifdef PREDICTOR_DECAY_EN
        @(negedge clock);
        @(negedge clock);
        chk("halve_idx", dut.idx, 1);
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s += dut.cnt[i][j];
            end
        end
        chk("mid_rst_cnt_sum",   s,             0);
        chk("mid_rst_ready",     pif.ready,     1);
        chk("mid_rst_choice",    pif.choice,    2);
        chk("mid_rst_predicted", pif.predicted, 0);
        chk("mid_rst_last_move", pif.last_move, 0);
        send(2'b01, lat);
        chk("mid_rst_first_lat", lat, 1);
        chk("mid_rst_first_cnt", dut.cnt[0][1], 0);

        // Reset wins over a simultaneous round_valid.
        @(negedge clock);
        reset           = 1'b1;
        pif.round_valid = 1'b1;
        pif.user        = 2'b10;
        @(negedge clock);
        reset           = 1'b0;
        pif.round_valid = 1'b0;
        pif.user        = 2'b00;
        chk("rst_prio_last_move", pif.last_move, 0);
        chk("rst_prio_ready",     pif.ready,     1);
        send(2'b10, lat);
        chk("rst_prio_first_lat", lat, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/transition_predictor.md
# transition_predictor

First-order Markov opponent for the rock-paper-scissors game. It learns how often each user move follows each previous user move and predicts the user's next move. It outputs the move that beats that prediction. It sits directly upstream of the game's computer-choice mux: its `choice`/`ready` feed the mux and the round scorer. That mux consumes `choice` only while `ready` is high.

## Interface
Parameters:
- `CNT_W`, default 4: width of each transition counter; max count = 2^CNT_W − 1.

Ports:
- `clock`  in  1  system clock (CLOCK_50).
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `round_valid`  in  1  one-cycle pulse: user move for the round is committed.
- `user`  in  2  user move, sampled with `round_valid`: 00 rock, 01 scissor, 10 paper, 11 invalid.
- `choice`  out  2  computer move for the next round, same encoding as `user`.
- `predicted`  out  2  predicted next user move.
- `ready`  out  1  `choice` is valid for the next round.
- `overrun`  out  1  one-cycle pulse: a `round_valid` was dropped while busy.
- `last_move`  out  2  most recently accepted user move; 00 before any round is accepted.

## Operation
- Table: 9 counters `cnt[prev][next]`, each `CNT_W` bits, indexed by move code 0..2.
- FSM states: EMPTY, READY, UPDATE, HALVE, PREDICT.
- **EMPTY**: entered on reset. No history; `ready`=1.
  - `round_valid` with a valid `user`: latch `last_move`=`user`, set has_prev, go to PREDICT.
  - No counter is incremented.
- **READY**: `ready`=1.
  - `round_valid` with a valid `user`: latch prev=`last_move`, `last_move`=`user`, go to UPDATE.
- **UPDATE**: target counter is `cnt[prev][last_move]`.
  - Target below max: increment it, go to PREDICT.
  - Target at max: go to HALVE with idx=0, or stay saturated (see Configuration).
- **HALVE**: one counter per cycle, `cnt[prev][idx] >>= 1`, idx 0→1→2.
  - After idx=2, return to UPDATE; the increment then succeeds.
- **PREDICT**: argmax over row `cnt[last_move][*]`.
  - Ties resolve to the lowest code, so an all-zero row predicts rock.
  - Register `predicted` = argmax.
  - Register `choice` = counter-move: rock→paper (10), scissor→rock (00), paper→scissor (01).
  - Go to READY.
- `user`=11 with `round_valid`: ignored in every state. No state change and no `overrun`.
- `round_valid` in UPDATE, HALVE or PREDICT: dropped. Table and FSM are unaffected; `overrun` pulses the next cycle.
- Counter arithmetic is unsigned `CNT_W`-bit. A counter never wraps.

## Timing
- Reset values:
  - State EMPTY, all counters 0, has_prev=0.
  - `last_move`=00, `predicted`=00, `choice`=10, `ready`=1, `overrun`=0.
- `ready` falls on the edge that samples an accepted `round_valid`.
- Latency from an accepted `round_valid` sampled at edge E0:
  - Non-saturating path: UPDATE at E1, PREDICT at E2. `ready`=1 and new `choice` valid after E2.
  - Saturating path (decay on): UPDATE E1, HALVE E2–E4, UPDATE E5, PREDICT E6. Ready after E6.
  - First round (from EMPTY): PREDICT at E1. Ready after E1.
- `choice` and `predicted` hold steady whenever `ready`=1. They change only at PREDICT.
- `overrun` is registered: it is high exactly one cycle, after the dropping edge.
- Reset in any state, including mid-HALVE: on that edge, return to reset values. Partial halving is discarded.
- Reset has priority over a simultaneous `round_valid`.

## Configuration
- `PREDICTOR_DECAY_EN` defined:
  - HALVE is compiled in.
  - Saturation of the target counter halves its row, then increments.
  - This keeps the table adaptive.
- `PREDICTOR_DECAY_EN` undefined:
  - No HALVE state.
  - A counter at max stays at max; UPDATE goes straight to PREDICT.
  - Latency is always the non-saturating path.

## Test plan
- Reset → `ready`=1, `choice`=10, `predicted`=00, `last_move`=00, `overrun`=0.
- Rounds rock, scissor → `cnt[R][S]`=1; row[S] is all zero so `predicted`=00, `choice`=10. A third round rock → row[R] has S=1, so `predicted`=01, `choice`=00, ready 2 edges after the pulse.
- `round_valid` one cycle after an accepted pulse (during UPDATE) → `overrun`=1 for one cycle; counters and final `choice` are identical to a run without the extra pulse. `user`=11 pulse in READY → no change, `overrun`=0.
- `CNT_W`=4, decay on, 16 rock→rock transitions → after the 15th `cnt[R][R]`=15; the 16th halves `cnt[R][R]` to 7, then increments it to 8, other row entries halved, ready 6 edges after the pulse. Decay off → stays 15, ready 2 edges after.
- Reset asserted during HALVE (idx=1) → next cycle all counters 0, state EMPTY, `choice`=10, `ready`=1.
